nco_multi_monitor: RTL and testbench
====================================

NCO_MULTI_MONITOR -- requirements
Module: nco_multi_monitor

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent NCO channels monitored.
REQ-002 Parameter SELECT_WIDTH, default 2: width of each channel's signal_out select field.
REQ-003 Parameter WAVE_WIDTH, default 8: width of each channel's wave_out sample.
REQ-004 Parameter MIN_HOLD, default 32: minimum cycles a select value SHALL persist.
REQ-005 Parameters LAT_MIN and LAT_MAX, both default 2: allowed select-to-wave response window in cycles; legal range is 1 <= LAT_MIN <= LAT_MAX < MIN_HOLD.
REQ-006 Parameter CNT_WIDTH, default 16: width of the error counter.
REQ-007 clk, input, 1: single clock; all state updates on its rising edge.
REQ-008 resetn, input, 1: asynchronous active-low reset.
REQ-009 chk_en, input, NUM_CH: per-channel check enable.
REQ-010 signal_out, input, NUM_CH*SELECT_WIDTH: packed per-channel select values, channel 0 in the LSBs.
REQ-011 wave_out, input, NUM_CH*WAVE_WIDTH: packed per-channel waveform samples, channel 0 in the LSBs.
REQ-012 err_clr, input, 1: synchronous one-cycle pulse that clears all sticky flags and err_count.
REQ-013 err_flags, output, NUM_CH*3: sticky flags per channel, ordered {lat, hold, rst} with rst in bit 0.
REQ-014 err_count, output, CNT_WIDTH: saturating total count of violations.
REQ-015 irq, output, 1: OR of all err_flags bits, registered.

Function
REQ-016 "Change" SHALL mean the sampled value differs from the value sampled on the previous edge; no change is detected on the first edge after reset release.
REQ-017 Reset check: on the first rising edge with resetn high, any channel with wave_out != 0 SHALL set its rst flag, regardless of chk_en.
REQ-018 Hold check: after a select change at edge t, a further change at t+k with k < MIN_HOLD SHALL set the hold flag, and that change SHALL start a new window.
REQ-019 A change at k >= MIN_HOLD is legal; the hold counter SHALL saturate at MIN_HOLD.
REQ-020 Latency check: a select change at t SHALL arm a window; the first wave_out change at t+k with LAT_MIN <= k <= LAT_MAX passes and disarms it.
REQ-021 A wave_out change at k < LAT_MIN SHALL set the lat flag and disarm the window.
REQ-022 No wave_out change by edge t+LAT_MAX SHALL set the lat flag at that edge.
REQ-023 A select change while a window is armed SHALL record the hold violation, abort the pending window without a lat error, and re-arm a new window.
REQ-024 Per-channel FSM states: IDLE (no window), ARMED (latency window open). The hold counter SHALL run independently of the FSM.
REQ-025 When chk_en[i] is low, channel i SHALL stay in IDLE with its hold counter saturated and report no hold or lat errors; its previous-value registers SHALL keep tracking.
REQ-026 Flags and irq SHALL become visible on the edge following the violation edge (one-cycle registered latency).
REQ-027 err_count SHALL add the number of new violations across all channels and types on each edge, saturating at all-ones.
REQ-028 When err_clr coincides with new violations, the clear SHALL apply first and the new violations SHALL set flags and load the count.

Reset
REQ-029 With resetn low, all flags, err_count, irq, and hold/latency counters SHALL be 0, the FSM SHALL be IDLE, and the previous-value registers SHALL be 0.
REQ-030 Reset asserted mid-window SHALL discard the window with no error reported.
REQ-031 The post-reset first-edge marker SHALL be set by reset and cleared after the first active edge.

Structure
REQ-032 Package nco_mon_pkg SHALL hold the error-index constants (ERR_RST=0, ERR_HOLD=1, ERR_LAT=2), the FSM state typedef, and the default parameter values.
REQ-033 Per-channel logic SHALL be sub-module nco_ch_monitor, instantiated NUM_CH times by generate; the top level SHALL own err_count, err_clr handling and irq.

Verification
REQ-034 Release reset with ch1 wave_out=0x05 and other channels 0 -> err_flags[3] (ch1 rst) = 1 and err_count = 1 one cycle later; irq = 1.
REQ-035 Defaults, ch0 select 0->1 at edge t and wave changes at t+2, then select held 40 cycles -> no flags, err_count = 0.
REQ-036 ch0 select changes at t, then again at t+10 -> hold flag set, err_count = 1, and a new window is armed at t+10.
REQ-037 LAT_MIN=2, LAT_MAX=4; ch2 select change with wave change first at t+1 -> lat error; repeat with no wave change -> lat error at t+4; err_count = 2.
REQ-038 Violations on ch0 and ch3 on the same edge as err_clr, with err_count = 7 -> err_count = 2 and both flags set.
REQ-039 CNT_WIDTH=4 with 20 forced violations -> err_count stays 15; with chk_en=0, select toggles every cycle -> no hold or lat flags.

Source files
------------

// File: rtl/nco_mon_pkg.sv
// Shared constants and types for the multi-channel NCO select/wave monitor.
// Error indices give the bit order of each channel's {lat, hold, rst} flag triple.
package nco_mon_pkg;

    localparam int ERR_RST   = 0;
    localparam int ERR_HOLD  = 1;
    localparam int ERR_LAT   = 2;
    localparam int ERR_TYPES = 3;

    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_SELECT_WIDTH = 2;
    localparam int DEF_WAVE_WIDTH   = 8;
    localparam int DEF_MIN_HOLD     = 32;
    localparam int DEF_LAT_MIN      = 2;
    localparam int DEF_LAT_MAX      = 2;
    localparam int DEF_CNT_WIDTH    = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } ch_state_e;

endpackage

// File: rtl/nco_ch_monitor.sv
// One NCO channel: detects select/wave changes and reports the reset, hold and
// latency violations seen on the current edge as a combinational pulse vector.
module nco_ch_monitor
    import nco_mon_pkg::*;
#(
    parameter int SELECT_WIDTH = DEF_SELECT_WIDTH,
    parameter int WAVE_WIDTH   = DEF_WAVE_WIDTH,
    parameter int MIN_HOLD     = DEF_MIN_HOLD,
    parameter int LAT_MIN      = DEF_LAT_MIN,
    parameter int LAT_MAX      = DEF_LAT_MAX
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    i_en,
    input  logic [SELECT_WIDTH-1:0] i_sel,
    input  logic [WAVE_WIDTH-1:0]   i_wave,
    output logic [ERR_TYPES-1:0]    o_viol
);

    localparam int HW = $clog2(MIN_HOLD + 1);
    localparam int LW = $clog2(LAT_MAX + 1);
    localparam logic [HW-1:0] HOLD_SAT = HW'(MIN_HOLD);
    localparam logic [LW-1:0] LMIN     = LW'(LAT_MIN);
    localparam logic [LW-1:0] LMAX     = LW'(LAT_MAX);

    ch_state_e               r_state, w_state_nxt;
    logic                    r_first;
    logic [SELECT_WIDTH-1:0] r_prev_sel;
    logic [WAVE_WIDTH-1:0]   r_prev_wave;
    logic [HW-1:0]           r_hold_cnt, w_hold_nxt;
    logic [LW-1:0]           r_lat_cnt, w_lat_nxt;
    logic                    w_sel_chg, w_wave_chg;
    logic                    w_viol_hold, w_viol_lat;

    assign w_sel_chg  = !r_first && (i_sel != r_prev_sel);
    assign w_wave_chg = !r_first && (i_wave != r_prev_wave);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_first     <= 1'b1;
            r_prev_sel  <= '0;
            r_prev_wave <= '0;
            r_hold_cnt  <= '0;
            r_lat_cnt   <= '0;
            r_state     <= ST_IDLE;
        end else begin
            r_first     <= 1'b0;
            r_prev_sel  <= i_sel;
            r_prev_wave <= i_wave;
            r_hold_cnt  <= w_hold_nxt;
            r_lat_cnt   <= w_lat_nxt;
            r_state     <= w_state_nxt;
        end
    end

    // Hold count of 0 means no select change seen yet, so nothing to violate.
    always_comb begin
        w_hold_nxt  = r_hold_cnt;
        w_viol_hold = 1'b0;
        if (!i_en) begin
            w_hold_nxt = HOLD_SAT;
        end else if (w_sel_chg) begin
            w_viol_hold = (r_hold_cnt != '0) && (r_hold_cnt < HOLD_SAT);
            w_hold_nxt  = HW'(1);
        end else if ((r_hold_cnt != '0) && (r_hold_cnt < HOLD_SAT)) begin
            w_hold_nxt = r_hold_cnt + HW'(1);
        end
    end

    // A select change always (re)arms; it silently aborts any open window.
    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat_cnt;
        w_viol_lat  = 1'b0;
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
            w_lat_nxt   = '0;
        end else if (w_sel_chg) begin
            w_state_nxt = ST_ARMED;
            w_lat_nxt   = LW'(1);
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_wave_chg) begin
                        w_viol_lat  = (r_lat_cnt < LMIN);
                        w_state_nxt = ST_IDLE;
                        w_lat_nxt   = '0;
                    end else if (r_lat_cnt >= LMAX) begin
                        w_viol_lat  = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_lat_nxt   = '0;
                    end else begin
                        w_lat_nxt = r_lat_cnt + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_viol[ERR_RST]  = r_first && (i_wave != '0);
    assign o_viol[ERR_HOLD] = w_viol_hold;
    assign o_viol[ERR_LAT]  = w_viol_lat;

endmodule

// File: rtl/nco_multi_monitor.sv
// Multi-channel NCO monitor: per-channel checkers plus sticky flags, a
// saturating violation counter and a registered interrupt.
module nco_multi_monitor
    import nco_mon_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int SELECT_WIDTH = DEF_SELECT_WIDTH,
    parameter int WAVE_WIDTH   = DEF_WAVE_WIDTH,
    parameter int MIN_HOLD     = DEF_MIN_HOLD,
    parameter int LAT_MIN      = DEF_LAT_MIN,
    parameter int LAT_MAX      = DEF_LAT_MAX,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_CH-1:0]              chk_en,
    input  logic [NUM_CH*SELECT_WIDTH-1:0] signal_out,
    input  logic [NUM_CH*WAVE_WIDTH-1:0]   wave_out,
    input  logic                           err_clr,
    output logic [NUM_CH*ERR_TYPES-1:0]    err_flags,
    output logic [CNT_WIDTH-1:0]           err_count,
    output logic                           irq
);

    localparam int NV    = NUM_CH * ERR_TYPES;
    localparam int SUM_W = CNT_WIDTH + $clog2(NV + 1);
    localparam logic [SUM_W-1:0] CNT_SAT = SUM_W'({CNT_WIDTH{1'b1}});

    logic [NV-1:0]        w_viol;
    logic [NV-1:0]        r_flags, w_flags_nxt;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                 r_irq;
    logic [SUM_W-1:0]     w_new_cnt, w_sum;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        nco_ch_monitor #(
            .SELECT_WIDTH (SELECT_WIDTH),
            .WAVE_WIDTH   (WAVE_WIDTH),
            .MIN_HOLD     (MIN_HOLD),
            .LAT_MIN      (LAT_MIN),
            .LAT_MAX      (LAT_MAX)
        ) u_ch (
            .clk    (clk),
            .resetn (resetn),
            .i_en   (chk_en[g]),
            .i_sel  (signal_out[g*SELECT_WIDTH +: SELECT_WIDTH]),
            .i_wave (wave_out[g*WAVE_WIDTH +: WAVE_WIDTH]),
            .o_viol (w_viol[g*ERR_TYPES +: ERR_TYPES])
        );
    end

    always_comb begin
        w_new_cnt = '0;
        for (int i = 0; i < NV; i++) begin
            w_new_cnt = w_new_cnt + SUM_W'(w_viol[i]);
        end
    end

    // Clear wins first; same-edge violations then land on the cleared state.
    always_comb begin
        w_flags_nxt = (err_clr ? '0 : r_flags) | w_viol;
        w_sum       = (err_clr ? '0 : SUM_W'(r_cnt)) + w_new_cnt;
        w_cnt_nxt   = (w_sum > CNT_SAT) ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_flags <= '0;
            r_cnt   <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_flags <= w_flags_nxt;
            r_cnt   <= w_cnt_nxt;
            r_irq   <= |w_flags_nxt;
        end
    end

    assign err_flags = r_flags;
    assign err_count = r_cnt;
    assign irq       = r_irq;

endmodule

// File: tb/tb_nco_multi_monitor.sv
// Bench for nco_multi_monitor: two instances (default latency/counter and a
// wide-window 4-bit-counter variant) driven in parallel against an edge-time model.
module tb_nco_multi_monitor;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  chk_en;
    logic [7:0]  sel;
    logic [31:0] wave;
    logic        err_clr;
    logic [11:0] flags0, flags1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    logic        irq0, irq1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    nco_multi_monitor u_dut0 (
        .clk(clk), .resetn(resetn), .chk_en(chk_en), .signal_out(sel),
        .wave_out(wave), .err_clr(err_clr), .err_flags(flags0),
        .err_count(cnt0), .irq(irq0)
    );

    nco_multi_monitor #(.LAT_MIN(2), .LAT_MAX(4), .CNT_WIDTH(4)) u_dut1 (
        .clk(clk), .resetn(resetn), .chk_en(chk_en), .signal_out(sel),
        .wave_out(wave), .err_clr(err_clr), .err_flags(flags1),
        .err_count(cnt1), .irq(irq1)
    );

    // Model: tracks edge numbers of the last select change and window start.
    localparam int MIN_HOLD = 32;
    localparam int LMIN     = 2;
    int          n = 0;
    bit          m_first = 1'b1;
    logic [1:0]  m_psel [2][4];
    logic [7:0]  m_pwave[2][4];
    int          m_last [2][4];
    bit          m_armed[2][4];
    int          m_arm  [2][4];
    logic [11:0] m_flags[2];
    int          m_cnt  [2];
    bit          m_irq  [2];

    function automatic int lmax(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int cmax(input int d);
        return (d == 0) ? 65535 : 15;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_first = 1'b1;
            for (int d = 0; d < 2; d++) begin
                m_flags[d] = '0; m_cnt[d] = 0; m_irq[d] = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    m_psel[d][c] = '0; m_pwave[d][c] = '0;
                    m_last[d][c] = -1; m_armed[d][c] = 1'b0; m_arm[d][c] = 0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic [11:0] nv;
                int          tot;
                nv = '0;
                for (int c = 0; c < 4; c++) begin
                    logic [1:0] s;
                    logic [7:0] w;
                    s = sel[c*2 +: 2];
                    w = wave[c*8 +: 8];
                    if (m_first) begin
                        if (w != 0) nv[c*3] = 1'b1;
                    end else if (!chk_en[c]) begin
                        m_last[d][c]  = -1;
                        m_armed[d][c] = 1'b0;
                    end else if (s != m_psel[d][c]) begin
                        if (m_last[d][c] >= 0 && n - m_last[d][c] < MIN_HOLD) nv[c*3+1] = 1'b1;
                        m_last[d][c]  = n;
                        m_armed[d][c] = 1'b1;
                        m_arm[d][c]   = n;
                    end else if (m_armed[d][c]) begin
                        if (w != m_pwave[d][c]) begin
                            if (n - m_arm[d][c] < LMIN) nv[c*3+2] = 1'b1;
                            m_armed[d][c] = 1'b0;
                        end else if (n - m_arm[d][c] >= lmax(d)) begin
                            nv[c*3+2] = 1'b1;
                            m_armed[d][c] = 1'b0;
                        end
                    end
                    m_psel[d][c]  = s;
                    m_pwave[d][c] = w;
                end
                m_flags[d] = (err_clr ? 12'h000 : m_flags[d]) | nv;
                tot        = (err_clr ? 0 : m_cnt[d]) + $countones(nv);
                m_cnt[d]   = (tot > cmax(d)) ? cmax(d) : tot;
                m_irq[d]   = |m_flags[d];
            end
            m_first = 1'b0;
            n++;
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("flags0", flags0, m_flags[0]);
        check("count0", cnt0, m_cnt[0]);
        check("irq0", irq0, m_irq[0]);
        check("flags1", flags1, m_flags[1]);
        check("count1", cnt1, m_cnt[1]);
        check("irq1", irq1, m_irq[1]);
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int c, input logic [1:0] v);
        sel[c*2 +: 2] = v;
    endtask

    task automatic set_wave(input int c, input logic [7:0] v);
        wave[c*8 +: 8] = v;
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [11:0] f0, input int c0,
                       input logic [11:0] f1, input int c1);
        check({nm, ".flags0"}, flags0, f0);
        check({nm, ".count0"}, cnt0, c0);
        check({nm, ".flags1"}, flags1, f1);
        check({nm, ".count1"}, cnt1, c1);
    endtask

    initial begin
        resetn = 1'b0; chk_en = 4'hF; sel = '0; wave = '0; err_clr = 1'b0;
        set_wave(1, 8'h05);
        step(3);
        lit("reset", 12'h000, 0, 12'h000, 0);
        check("reset.irq0", irq0, 0);

        // Nonzero wave on ch1 at the first active edge.
        resetn = 1'b1;
        step(1);
        lit("rst_chk", 12'h008, 1, 12'h008, 1);
        check("rst_chk.irq0", irq0, 1);
        step(2);
        clr_pulse();
        lit("clr", 12'h000, 0, 12'h000, 0);
        check("clr.irq0", irq0, 0);

        // Clean select change, wave answers at t+2, long hold.
        set_sel(0, 2'd1); step(2);
        set_wave(0, 8'h10); step(40);
        lit("clean", 12'h000, 0, 12'h000, 0);

        // Second select change only 10 edges later.
        set_sel(0, 2'd2); step(2);
        set_wave(0, 8'h20); step(8);
        set_sel(0, 2'd3); step(1);
        lit("hold", 12'h002, 1, 12'h002, 1);
        step(1);
        set_wave(0, 8'h30); step(40);
        lit("hold_rearm", 12'h002, 1, 12'h002, 1);
        clr_pulse();

        // ch2: early wave response, then no response at all.
        set_sel(2, 2'd1); step(1);
        set_wave(2, 8'h01); step(1);
        lit("lat_early", 12'h100, 1, 12'h100, 1);
        step(40);
        set_sel(2, 2'd2); step(2);
        lit("lat_t1", 12'h100, 1, 12'h100, 1);
        step(1);
        lit("lat_t2", 12'h100, 2, 12'h100, 1);
        step(2);
        lit("lat_t4", 12'h100, 2, 12'h100, 2);
        step(40);
        clr_pulse();

        // Seven hold violations on ch1, then ch0/ch3 lat errors on the clear edge.
        for (int i = 0; i < 8; i++) begin
            set_sel(1, sel[3:2] ^ 2'b01);
            step(1);
        end
        lit("cnt7", 12'h010, 7, 12'h010, 7);
        step(1);
        set_wave(1, 8'h06); step(1);
        set_sel(0, 2'd0); set_sel(3, 2'd1); step(1);
        set_wave(0, 8'h40); set_wave(3, 8'h01); err_clr = 1'b1; step(1);
        err_clr = 1'b0;
        lit("clr_coinc", 12'h804, 2, 12'h804, 2);
        check("clr_coinc.irq1", irq1, 1);
        clr_pulse();
        step(40);

        // Twenty hold violations: 4-bit counter saturates.
        for (int i = 0; i < 21; i++) begin
            set_sel(1, sel[3:2] ^ 2'b10);
            step(1);
        end
        step(1);
        set_wave(1, 8'h07); step(2);
        lit("sat", 12'h010, 20, 12'h010, 15);
        clr_pulse();
        step(40);

        // ch2 disabled: rapid toggling reports nothing.
        chk_en = 4'b1011;
        for (int i = 0; i < 10; i++) begin
            set_sel(2, sel[5:4] + 2'd1);
            step(1);
        end
        step(10);
        lit("disabled", 12'h000, 0, 12'h000, 0);
        chk_en = 4'hF; step(1);
        set_sel(2, sel[5:4] + 2'd1); step(2);
        set_wave(2, 8'h02); step(5);
        lit("reenabled", 12'h000, 0, 12'h000, 0);

        // Reset in the middle of an armed window.
        set_sel(3, 2'd2); step(1);
        resetn = 1'b0; wave = '0; step(2);
        lit("midrst", 12'h000, 0, 12'h000, 0);
        resetn = 1'b1; step(10);
        lit("post_rst", 12'h000, 0, 12'h000, 0);
        check("post_rst.irq1", irq1, 0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
